// File: rtl/cpm5_rc_credit_sink_pkg.sv
// Shared types and constants for the RC credit sink and its bench.
package cpm5_rc_sink_pkg;

    localparam int RC_SINK_DEFAULT_DEPTH = 16;
    localparam int RC_DATA_W             = 512;
    localparam int RC_USER_W             = 161;
    localparam int RC_KEEP_W             = RC_DATA_W / 32;

    // One RC beat as it travels through the sink.
    typedef struct packed {
        logic [RC_DATA_W-1:0] tdata;
        logic [RC_USER_W-1:0] tuser;
        logic                 tlast;
        logic [RC_KEEP_W-1:0] tkeep;
    } rc_beat_t;

    // Flattened width of one beat for a given data/user width.
    function automatic int rc_beat_bits(input int data_w, input int user_w);
        return data_w + user_w + 1 + data_w / 32;
    endfunction

endpackage

// File: rtl/cpm5_rc_credit_sink_if.sv
// RC channel bundle: credit-flow input stream plus AXI4-Stream output.
interface cpm5_rc_credit_sink_if #(
    parameter int DATA_WIDTH = cpm5_rc_sink_pkg::RC_DATA_W,
    parameter int USER_WIDTH = cpm5_rc_sink_pkg::RC_USER_W
);
    localparam int KEEP_WIDTH = DATA_WIDTH / 32;

    // Credit-flow side (from the CPM5 block)
    logic [DATA_WIDTH-1:0] s_rc_tdata;
    logic [USER_WIDTH-1:0] s_rc_tuser;
    logic                  s_rc_tlast;
    logic [KEEP_WIDTH-1:0] s_rc_tkeep;
    logic                  s_rc_tvalid;
    logic                  s_rc_credit;

    // Valid/ready side (toward the completion logic)
    logic [DATA_WIDTH-1:0] m_rc_tdata;
    logic [USER_WIDTH-1:0] m_rc_tuser;
    logic                  m_rc_tlast;
    logic [KEEP_WIDTH-1:0] m_rc_tkeep;
    logic                  m_rc_tvalid;
    logic                  m_rc_tready;

    // Environment view: drives incoming beats and downstream ready.
    modport master (
        output s_rc_tdata, s_rc_tuser, s_rc_tlast, s_rc_tkeep, s_rc_tvalid,
        input  s_rc_credit,
        input  m_rc_tdata, m_rc_tuser, m_rc_tlast, m_rc_tkeep, m_rc_tvalid,
        output m_rc_tready
    );

    // Sink view: absorbs beats, returns credits, presents the stream.
    modport slave (
        input  s_rc_tdata, s_rc_tuser, s_rc_tlast, s_rc_tkeep, s_rc_tvalid,
        output s_rc_credit,
        output m_rc_tdata, m_rc_tuser, m_rc_tlast, m_rc_tkeep, m_rc_tvalid,
        input  m_rc_tready
    );

endinterface

// File: rtl/cpm5_sync_fifo.sv
// Generic single-clock FIFO. The head entry is held in a register so the
// read side sees a stable, registered word; a write is visible the cycle
// after it is taken (no fall-through).
module cpm5_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       din_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       dout_o,
    output logic [$clog2(DEPTH):0] level_o,
    output logic                   full_o,
    output logic                   empty_o
);
    localparam int              PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W:0]  FULL_LVL = (PTR_W+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   level_q, level_d, remain;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             push_ok, pop_ok;

    assign full_o  = (level_q == FULL_LVL);
    assign empty_o = (level_q == '0);
    // A full FIFO refuses a write even when a read happens in the same cycle.
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;

    // Next pointers/occupancy; head register tracks mem[rd_ptr] when non-empty.
    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop_ok);
        remain   = level_q - (PTR_W+1)'(pop_ok);
        level_d  = remain + (PTR_W+1)'(push_ok);
        dout_d   = dout_q;
        if (push_ok && remain == '0) begin
            dout_d = din_i;
        end else if (pop_ok && remain != '0) begin
            dout_d = mem_q[rd_ptr_d];
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    // Pointer, occupancy and head-register state with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            dout_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            dout_q   <= dout_d;
        end
    end

    assign dout_o  = dout_q;
    assign level_o = level_q;

endmodule

// File: rtl/cpm5_rc_credit_sink.sv
// Credit-based RC receiver: advertises one-beat credits, buffers incoming
// beats and re-presents them as a valid/ready stream. Every beat drained
// downstream earns back one credit.
module cpm5_rc_credit_sink
    import cpm5_rc_sink_pkg::*;
#(
    parameter int DATA_WIDTH = RC_DATA_W,
    parameter int USER_WIDTH = RC_USER_W,
    parameter int DEPTH      = RC_SINK_DEFAULT_DEPTH
) (
    input  logic                        user_clk,
    input  logic                        user_reset,
    cpm5_rc_credit_sink_if.slave        rc,
    output logic [$clog2(DEPTH):0]      fifo_level,
    output logic [$clog2(DEPTH):0]      credit_owed,
    output logic                        overflow_err
);
    localparam int LVL_W  = $clog2(DEPTH) + 1;
    localparam int BEAT_W = rc_beat_bits(DATA_WIDTH, USER_WIDTH);

    logic [BEAT_W-1:0] wr_beat, rd_beat;
    logic [LVL_W-1:0]  level;
    logic              fifo_full, fifo_empty;
    logic              push, pop;
    logic [LVL_W-1:0]  owed_q, owed_d;
    logic              credit_q, credit_d;
    logic              ovf_q, ovf_d;

    // Beats arriving during reset are ignored; beats arriving while full are dropped.
    assign wr_beat = {rc.s_rc_tdata, rc.s_rc_tuser, rc.s_rc_tlast, rc.s_rc_tkeep};
    assign push    = rc.s_rc_tvalid & ~fifo_full & ~user_reset;
    assign pop     = ~fifo_empty & rc.m_rc_tready;

    cpm5_sync_fifo #(
        .WIDTH (BEAT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (user_clk),
        .rst_i   (user_reset),
        .push_i  (push),
        .din_i   (wr_beat),
        .pop_i   (pop),
        .dout_o  (rd_beat),
        .level_o (level),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Credit bookkeeping: the pulse on the wire is registered from the next
    // owed count, so a credit still counts as owed during the cycle it is shown.
    always_comb begin
        owed_d   = owed_q + LVL_W'(pop) - LVL_W'(credit_q);
        credit_d = (owed_d != '0);
        ovf_d    = ovf_q | (rc.s_rc_tvalid & fifo_full);
    end

    // Credit counter, credit pulse and sticky overflow flag.
    always_ff @(posedge user_clk) begin
        if (user_reset) begin
            owed_q   <= LVL_W'(DEPTH);
            credit_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            owed_q   <= owed_d;
            credit_q <= credit_d;
            ovf_q    <= ovf_d;
        end
    end

    // The credit pool can never hold more than the buffer it stands for.
    assert property (@(posedge user_clk) disable iff (user_reset) owed_q <= LVL_W'(DEPTH));

    assign {rc.m_rc_tdata, rc.m_rc_tuser, rc.m_rc_tlast, rc.m_rc_tkeep} = rd_beat;
    assign rc.m_rc_tvalid = ~fifo_empty;
    assign rc.s_rc_credit = credit_q;
    assign fifo_level     = level;
    assign credit_owed    = owed_q;
    assign overflow_err   = ovf_q;

endmodule

// File: tb/tb_cpm5_rc_credit_sink.sv
// Bench for cpm5_rc_credit_sink: table of cycle vectors, hand-written corner
// sequences and randomized credit-obeying traffic against a queue model.
module tb_cpm5_rc_credit_sink;
    import cpm5_rc_sink_pkg::*;

    localparam int DW    = RC_DATA_W;
    localparam int UW    = RC_USER_W;
    localparam int KW    = RC_KEEP_W;
    localparam int DEPTH = 16;
    localparam int LW    = 5;

    logic          user_clk = 1'b0;
    logic          user_reset;
    logic [LW-1:0] fifo_level;
    logic [LW-1:0] credit_owed;
    logic          overflow_err;

    cpm5_rc_credit_sink_if #(.DATA_WIDTH(DW), .USER_WIDTH(UW)) rc ();

    cpm5_rc_credit_sink #(
        .DATA_WIDTH (DW),
        .USER_WIDTH (UW),
        .DEPTH      (DEPTH)
    ) dut (
        .user_clk     (user_clk),
        .user_reset   (user_reset),
        .rc           (rc),
        .fifo_level   (fifo_level),
        .credit_owed  (credit_owed),
        .overflow_err (overflow_err)
    );

    always #5 user_clk = ~user_clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: beat queue plus credit counts.
    rc_beat_t q[$];
    int       m_owed   = DEPTH;
    bit       m_credit = 1'b0;
    bit       m_ovf    = 1'b0;
    bit       m_zero   = 1'b1;

    // Sender / stimulus state
    rc_beat_t drv;
    bit       send_en     = 1'b0;
    int       send_pct    = 100;
    int       send_budget = 0;
    int       tb_credits  = 0;
    int       tready_pct  = -1;

    // Statistics
    int cyc          = 0;
    int credits_seen = 0;
    int pops_seen    = 0;
    int first_pop    = -1;
    int last_pop     = -1;
    int max_level    = 0;

    typedef struct {
        bit rst;
        bit tvalid;
        bit tready;
        bit e_credit;
        bit e_tvalid;
        int e_level;
        int e_owed;
        bit e_ovf;
    } vec_t;

    vec_t tbl[27];

    task automatic check_bit(input string name, input logic got, input logic exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b expected %0b (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic check_beat(input string name, input rc_beat_t got, input rc_beat_t exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic rc_beat_t rand_beat();
        rc_beat_t b;
        for (int i = 0; i < DW / 32; i++) b.tdata[i*32 +: 32] = $urandom();
        b.tuser = UW'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
        b.tlast = 1'($urandom_range(1));
        b.tkeep = KW'($urandom());
        return b;
    endfunction

    function automatic rc_beat_t cur_out();
        rc_beat_t b;
        b.tdata = rc.m_rc_tdata;
        b.tuser = rc.m_rc_tuser;
        b.tlast = rc.m_rc_tlast;
        b.tkeep = rc.m_rc_tkeep;
        return b;
    endfunction

    // One clock: drive, advance model at the edge, compare #1 later.
    task automatic step();
        bit       pop_m;
        bit       push_m;
        bit       stall;
        rc_beat_t held;
        if (send_en) begin
            if (!user_reset && tb_credits > 0 && send_budget > 0 &&
                $urandom_range(99) < send_pct) begin
                drv = rand_beat();
                tb_credits--;
                send_budget--;
                rc.s_rc_tvalid = 1'b1;
            end else begin
                rc.s_rc_tvalid = 1'b0;
            end
        end
        if (tready_pct >= 0) rc.m_rc_tready = ($urandom_range(99) < tready_pct);
        rc.s_rc_tdata = drv.tdata;
        rc.s_rc_tuser = drv.tuser;
        rc.s_rc_tlast = drv.tlast;
        rc.s_rc_tkeep = drv.tkeep;
        pop_m = (q.size() != 0) && rc.m_rc_tready;
        stall = !user_reset && rc.m_rc_tvalid && !rc.m_rc_tready;
        held  = cur_out();
        @(posedge user_clk);
        if (user_reset) begin
            q.delete();
            m_owed     = DEPTH;
            m_credit   = 1'b0;
            m_ovf      = 1'b0;
            m_zero     = 1'b1;
            tb_credits = 0;
        end else begin
            if (rc.s_rc_tvalid && q.size() == DEPTH) m_ovf = 1'b1;
            push_m = rc.s_rc_tvalid && q.size() < DEPTH;
            if (pop_m) begin
                void'(q.pop_front());
                pops_seen++;
                if (first_pop < 0) first_pop = cyc;
                last_pop = cyc;
            end
            if (push_m) begin
                q.push_back(drv);
                m_zero = 1'b0;
            end
            m_owed   = m_owed + int'(pop_m) - int'(m_credit);
            m_credit = (m_owed != 0);
        end
        #1;
        cyc++;
        check_bit("m_rc_tvalid", rc.m_rc_tvalid, q.size() != 0);
        check_int("fifo_level", int'(fifo_level), q.size());
        check_int("credit_owed", int'(credit_owed), m_owed);
        check_bit("s_rc_credit", rc.s_rc_credit, m_credit);
        check_bit("overflow_err", overflow_err, m_ovf);
        if (q.size() != 0) check_beat("head_beat", cur_out(), q[0]);
        else if (m_zero)   check_beat("reset_payload", cur_out(), '0);
        if (stall && !user_reset) check_beat("stall_hold", cur_out(), held);
        if (rc.s_rc_credit) begin
            tb_credits++;
            credits_seen++;
        end
        if (int'(fifo_level) > max_level) max_level = int'(fifo_level);
    endtask

    task automatic do_reset();
        user_reset     = 1'b1;
        send_en        = 1'b0;
        rc.s_rc_tvalid = 1'b0;
        step();
        user_reset = 1'b0;
    endtask

    task automatic fill_full();
        send_en     = 1'b1;
        send_pct    = 100;
        send_budget = DEPTH;
        tready_pct  = -1;
        rc.m_rc_tready = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (int'(fifo_level) == DEPTH) break;
            step();
        end
        send_en        = 1'b0;
        rc.s_rc_tvalid = 1'b0;
        check_int("fill_level", int'(fifo_level), DEPTH);
    endtask

    initial begin
        user_reset     = 1'b1;
        rc.s_rc_tvalid = 1'b0;
        rc.m_rc_tready = 1'b0;
        drv            = '0;

        // ---- table-driven vectors from reset ----
        tbl[0] = '{1, 0, 0, 0, 0, 0, 16, 0};
        for (int i = 1; i <= 17; i++) tbl[i] = '{0, 0, 0, (17 - i) != 0, 0, 0, 17 - i, 0};
        tbl[18] = '{0, 1, 0, 0, 1, 1, 0, 0};
        tbl[19] = '{0, 1, 0, 0, 1, 2, 0, 0};
        tbl[20] = '{0, 1, 0, 0, 1, 3, 0, 0};
        tbl[21] = '{0, 0, 1, 1, 1, 2, 1, 0};
        tbl[22] = '{0, 1, 1, 1, 1, 2, 1, 0};
        tbl[23] = '{0, 0, 1, 1, 1, 1, 1, 0};
        tbl[24] = '{0, 0, 1, 1, 0, 0, 1, 0};
        tbl[25] = '{0, 0, 0, 0, 0, 0, 0, 0};
        tbl[26] = '{0, 0, 0, 0, 0, 0, 0, 0};
        for (int i = 0; i < 27; i++) begin
            user_reset     = tbl[i].rst;
            rc.s_rc_tvalid = tbl[i].tvalid;
            rc.m_rc_tready = tbl[i].tready;
            if (tbl[i].tvalid) drv = rand_beat();
            step();
            check_bit("tbl_credit", rc.s_rc_credit, tbl[i].e_credit);
            check_bit("tbl_tvalid", rc.m_rc_tvalid, tbl[i].e_tvalid);
            check_int("tbl_level", int'(fifo_level), tbl[i].e_level);
            check_int("tbl_owed", int'(credit_owed), tbl[i].e_owed);
            check_bit("tbl_ovf", overflow_err, tbl[i].e_ovf);
        end
        rc.s_rc_tvalid = 1'b0;
        rc.m_rc_tready = 1'b0;

        // ---- 16 credited beats, then drain: first credit right after first pop ----
        do_reset();
        fill_full();
        check_bit("no_credit_when_full", rc.s_rc_credit, 1'b0);
        rc.m_rc_tready = 1'b1;
        credits_seen   = 0;
        pops_seen      = 0;
        step();
        check_bit("credit_after_first_pop", rc.s_rc_credit, 1'b1);
        for (int i = 0; i < 20; i++) step();
        check_int("drain_pops", pops_seen, DEPTH);
        check_int("drain_credits", credits_seen, DEPTH);

        // ---- back-to-back 40-beat stream, credit loop closed ----
        do_reset();
        send_en = 1'b1; send_pct = 100; send_budget = 40; tready_pct = 100;
        pops_seen = 0; first_pop = -1; last_pop = -1; max_level = 0;
        for (int i = 0; i < 200; i++) begin
            if (pops_seen == 40) break;
            step();
        end
        check_int("stream_pops", pops_seen, 40);
        check_int("stream_contiguous", last_pop - first_pop + 1, 40);
        check_bit("stream_level_bound", max_level <= DEPTH, 1'b1);
        check_bit("stream_no_ovf", overflow_err, 1'b0);

        // ---- overflow while full with a simultaneous pop ----
        do_reset();
        fill_full();
        drv            = rand_beat();
        rc.s_rc_tvalid = 1'b1;
        rc.m_rc_tready = 1'b1;
        step();
        check_bit("ovf_set", overflow_err, 1'b1);
        check_int("ovf_level", int'(fifo_level), DEPTH - 1);
        rc.s_rc_tvalid = 1'b0;
        rc.m_rc_tready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_bit("ovf_sticky", overflow_err, 1'b1);
        end
        do_reset();
        check_bit("ovf_cleared", overflow_err, 1'b0);

        // ---- random stalls (about 30% tready low) ----
        do_reset();
        send_en = 1'b1; send_pct = 60; send_budget = 60; tready_pct = 70;
        pops_seen = 0; credits_seen = 0;
        for (int i = 0; i < 1000; i++) begin
            if (pops_seen == 60) break;
            step();
        end
        check_int("random_pops", pops_seen, 60);
        for (int i = 0; i < 40; i++) step();
        check_int("random_owed_drained", int'(credit_owed), 0);
        check_int("random_credits_vs_pops", credits_seen, DEPTH + pops_seen);

        // ---- reset mid-operation with level 7 and 3 credits owed ----
        do_reset();
        send_en = 1'b1; send_pct = 100; send_budget = 7; tready_pct = -1;
        rc.m_rc_tready = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (int'(credit_owed) == 3) break;
            step();
        end
        check_int("mid_pre_level", int'(fifo_level), 7);
        check_int("mid_pre_owed", int'(credit_owed), 3);
        send_en        = 1'b0;
        user_reset     = 1'b1;
        drv            = rand_beat();
        rc.s_rc_tvalid = 1'b1;
        step();
        check_int("mid_level", int'(fifo_level), 0);
        check_bit("mid_tvalid", rc.m_rc_tvalid, 1'b0);
        check_int("mid_owed", int'(credit_owed), DEPTH);
        check_bit("mid_ovf", overflow_err, 1'b0);
        check_bit("mid_credit", rc.s_rc_credit, 1'b0);
        user_reset     = 1'b0;
        rc.s_rc_tvalid = 1'b0;
        step();
        check_bit("mid_first_credit", rc.s_rc_credit, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
